// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of a 4:1 select mux. Drives the mux select
// lines (sel[1] -> S1, sel[0] -> S0), a one-hot grant and a busy flag.
// An owner that keeps requesting while others wait is rotated out after
// MAX_HOLD consecutive cycles; a sole requester keeps the grant forever.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       last_reg, last_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       grant_reg, grant_next;
    logic [1:0]       sel_reg, sel_next;
    logic             busy_reg, busy_next;

    // Requests rotated so that bit 0 is the requester right after last_reg.
    logic [3:0] rot_req;
    logic [1:0] win_ofs;
    logic [1:0] winner;
    logic [3:0] owner_mask;
    logic       owner_req;
    logic       others_req;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            logic [1:0] rot_idx;
            assign rot_idx     = last_reg + 2'(gi + 1);
            assign rot_req[gi] = req[rot_idx];
        end
    endgenerate

    // First set bit of the rotated vector gives the winner's distance from last+1.
    always_comb begin
        win_ofs = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_ofs = 2'(k);
            end
        end
    end

    assign winner     = last_reg + 2'd1 + win_ofs;
    assign owner_mask = 4'b0001 << last_reg;
    assign owner_req  = req[last_reg];
    assign others_req = |(req & ~owner_mask);

    // Next-state and registered-output decisions; every grant change reloads cnt and last.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        grant_next = grant_reg;
        sel_next   = sel_reg;
        busy_next  = busy_reg;
        case (state_reg)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_next = OWNED;
                    last_next  = winner;
                    cnt_next   = '0;
                    grant_next = 4'b0001 << winner;
                    sel_next   = winner;
                    busy_next  = 1'b1;
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    if (others_req) begin
                        last_next  = winner;
                        cnt_next   = '0;
                        grant_next = 4'b0001 << winner;
                        sel_next   = winner;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        grant_next = 4'b0000;
                        busy_next  = 1'b0;
                    end
                end else if ((cnt_reg == CNT_MAX) && others_req) begin
                    // Search starts at owner+1, so the owner cannot win again here.
                    last_next  = winner;
                    cnt_next   = '0;
                    grant_next = 4'b0001 << winner;
                    sel_next   = winner;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset parks last at 3 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= 2'd3;
            cnt_reg   <= '0;
            grant_reg <= 4'b0000;
            sel_reg   <= 2'b00;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            grant_reg <= grant_next;
            sel_reg   <= sel_next;
            busy_reg  <= busy_next;
        end
    end

    assign grant = grant_reg;
    assign sel   = sel_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: four instances (MAX_HOLD 8, 4, 2, 1) share one
// request vector and reset; each is compared every cycle against a
// cycle-count reference model, plus directed scenario checks.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;

    logic [3:0] d_grant [4];
    logic [1:0] d_sel   [4];
    logic       d_busy  [4];

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 idle), cycles held so far, last winner.
    int mh_tab  [4] = '{8, 4, 2, 1};
    int m_owner [4];
    int m_held  [4];
    int m_last  [4];
    int m_sel   [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            mux_rr_arbiter #(
                .MAX_HOLD((gi == 0) ? 8 : (gi == 1) ? 4 : (gi == 2) ? 2 : 1)
            ) dut (
                .clk   (clk),
                .rst   (rst),
                .req   (req),
                .grant (d_grant[gi]),
                .sel   (d_sel[gi]),
                .busy  (d_busy[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int search(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant(input int k);
        return (m_owner[k] < 0) ? 4'b0000 : 4'(1 << m_owner[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_last[k]  = 3;
            m_sel[k]   = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            int w;
            w = search(m_last[k], r);
            if (m_owner[k] < 0) begin
                if (w >= 0) begin
                    m_owner[k] = w; m_last[k] = w; m_sel[k] = w; m_held[k] = 1;
                end
            end else if (!r[m_owner[k]]) begin
                if (w >= 0) begin
                    m_owner[k] = w; m_last[k] = w; m_sel[k] = w; m_held[k] = 1;
                end else begin
                    m_owner[k] = -1;
                end
            end else if (m_held[k] >= mh_tab[k] && (r & ~(4'b0001 << m_owner[k])) != 4'b0000) begin
                m_owner[k] = w; m_last[k] = w; m_sel[k] = w; m_held[k] = 1;
            end else begin
                m_held[k]++;
            end
        end
    endtask

    // One clock edge: the model samples req at the edge, outputs are read at the next negedge.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_step(req);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_grant[k] !== 4'b0000 || d_sel[k] !== 2'b00 || d_busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d grant=%b sel=%b busy=%b want 0000/00/0",
                         k, d_grant[k], d_sel[k], d_busy[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_grant[k] !== 4'b0000 || d_busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_req inst%0d grant=%b busy=%b want 0000/0", k, d_grant[k], d_busy[k]);
            end
        end
    endtask

    task automatic test_basic_grant();
        apply_reset();
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (d_grant[k] !== 4'b0001 || d_sel[k] !== 2'b00 || d_busy[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_grant inst%0d cyc%0d grant=%b sel=%b busy=%b want 0001/00/1",
                             k, c, d_grant[k], d_sel[k], d_busy[k]);
                end
            end
        end
    endtask

    task automatic test_full_contention();
        apply_reset();
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            int idx;
            tick();
            idx = (c / 4) % 4;
            checks++;
            if (d_grant[1] !== 4'(1 << idx) || d_sel[1] !== 2'(idx) || d_busy[1] !== 1'b1) begin
                errors++;
                $display("FAIL full_contention cyc%0d grant=%b sel=%b want %b/%0d",
                         c, d_grant[1], d_sel[1], 4'(1 << idx), idx);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (d_grant[k] !== exp_grant(k) || d_sel[k] !== 2'(m_sel[k]) || d_busy[k] !== (m_owner[k] >= 0)) begin
                    errors++;
                    $display("FAIL contention_model inst%0d cyc%0d grant=%b sel=%b want %b/%0d",
                             k, c, d_grant[k], d_sel[k], exp_grant(k), m_sel[k]);
                end
            end
        end
    endtask

    task automatic test_release_handoff();
        apply_reset();
        req = 4'b0101;
        tick();
        req = 4'b0100;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_grant[k] !== 4'b0100 || d_sel[k] !== 2'b10 || d_busy[k] !== 1'b1) begin
                errors++;
                $display("FAIL release_handoff inst%0d grant=%b sel=%b busy=%b want 0100/10/1",
                         k, d_grant[k], d_sel[k], d_busy[k]);
            end
        end
        req = 4'b0000;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_grant[k] !== 4'b0000 || d_sel[k] !== 2'b10 || d_busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL release_idle inst%0d grant=%b sel=%b busy=%b want 0000/10/0",
                         k, d_grant[k], d_sel[k], d_busy[k]);
            end
        end
    endtask

    task automatic test_wrap_around();
        logic [3:0] want [4] = '{4'b1000, 4'b0001, 4'b0001, 4'b1000};
        apply_reset();
        req = 4'b1000;
        tick();
        req = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (d_grant[2] !== want[c]) begin
                errors++;
                $display("FAIL wrap_around cyc%0d grant=%b want %b", c, d_grant[2], want[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 4'b0100;
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_grant[k] !== 4'b0000 || d_sel[k] !== 2'b00 || d_busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid inst%0d grant=%b sel=%b busy=%b want 0000/00/0",
                         k, d_grant[k], d_sel[k], d_busy[k]);
            end
        end
        req = 4'b1111;
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_grant[k] !== 4'b0001 || d_sel[k] !== 2'b00) begin
                errors++;
                $display("FAIL reset_first_grant inst%0d grant=%b sel=%b want 0001/00", k, d_grant[k], d_sel[k]);
            end
        end
    endtask

    task automatic test_max_hold_one();
        apply_reset();
        req = 4'b0110;
        for (int c = 0; c < 10; c++) begin
            logic [3:0] w;
            tick();
            w = (c % 2 == 0) ? 4'b0010 : 4'b0100;
            checks++;
            if (d_grant[3] !== w) begin
                errors++;
                $display("FAIL max_hold_one cyc%0d grant=%b want %b", c, d_grant[3], w);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
            tick();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (d_grant[k] !== exp_grant(k) || d_sel[k] !== 2'(m_sel[k]) || d_busy[k] !== (m_owner[k] >= 0)) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d req=%b grant=%b sel=%b busy=%b want %b/%0d/%0d",
                             k, c, req, d_grant[k], d_sel[k], d_busy[k], exp_grant(k), m_sel[k], m_owner[k] >= 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_full_contention();
        test_release_handoff();
        test_wrap_around();
        test_reset_mid();
        test_max_hold_one();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 select mux (data inputs routed by S1:S0) among four requesters. It drives the mux select lines and a one-hot grant. Under contention it enforces a bounded hold time so that no requester can monopolise the mux output. It sits directly in front of the mux: `sel[1]` drives S1 and `sel[0]` drives S0.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester keeps the grant while another requester is pending. Must be ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  4  request vector; `req[i]` = requester i wants the mux output.
- `grant`  out  4  one-hot grant, or 0 when idle; registered.
- `sel`  out  2  binary index of the granted requester, driving S1:S0; registered; holds its last value when idle.
- `busy`  out  1  high when `grant` is nonzero; registered.

## Operation
- State machine with two states, IDLE and OWNED. Internal state:
  - `last`, 2 bits: the most recently granted index.
  - `cnt`, `$clog2(MAX_HOLD)` bits, minimum 1: cycles held by the current owner.
- Priority search: from `last+1` upward, wrapping 3→0, pick the first set `req` bit.
- IDLE:
  - If `req` == 0, stay in IDLE.
  - Otherwise grant the priority-search winner, set `last` = winner, `cnt` = 0, and go to OWNED.
- OWNED, with owner `o`:
  - **Release:** if `req[o]` == 0, the owner releases.
    - If any other `req` bit is set, grant the next winner directly, with no idle cycle.
    - Otherwise go to IDLE; `grant` and `busy` go to 0.
  - **Preemption:** if `req[o]` == 1, `cnt` == MAX_HOLD−1, and any other `req` bit is set, rotate to the priority-search winner, which excludes `o` because the search starts at `o+1`. Reset `cnt` to 0.
  - **Hold:** otherwise keep `o`. `cnt` increments and saturates at MAX_HOLD−1.
  - **Sole requester:** if the owner is the only requester, it keeps the grant indefinitely.
- On every change of grant, `cnt` resets to 0 and `last` updates.
- `grant`, `sel` and `busy` always agree on the same clock edge.
- `grant` is never multi-hot.
- With MAX_HOLD = 1, every pending requester rotates every cycle.

## Timing
- Reset values: `grant` = 0000, `sel` = 00, `busy` = 0, `last` = 3 (so req0 wins first), `cnt` = 0, state = IDLE.
- Reset takes effect immediately and asynchronously, including in the middle of a grant. The first edge after `rst` deasserts is evaluated from IDLE.
- Latency: `req` is sampled at edge k; the resulting grant and `sel` are visible after edge k.
- A single request therefore sees a 1-cycle request-to-grant delay.
- Owner handoff on release or preemption takes exactly one edge, with no dead cycle.
- Under full contention each requester holds exactly MAX_HOLD cycles.
- Worst-case wait from `req` assertion to grant: 3·MAX_HOLD + 1 cycles.
- A requester that drops and re-raises `req` between edges is not seen. `req` is level-sampled only at edges.
- Simultaneous events:
  - Owner release together with other requests: the release wins and the next winner is granted.
  - Owner release together with no requests: go to IDLE.

## Test plan
- **Basic grant:** `rst` pulse, then `req` = 0001 held.
  - After the first edge: `grant` = 0001, `sel` = 00, `busy` = 1.
  - Stays granted for 20 cycles with no rotation.
- **Full contention:** MAX_HOLD = 4, `req` = 1111.
  - Grant sequence is 0001×4, 0010×4, 0100×4, 1000×4 cycles, then repeats.
  - `sel` follows 00, 01, 10, 11.
- **Release handoff:** owner 0 with `req` = 0101; drop `req[0]` (`req` = 0100).
  - Next edge: `grant` = 0100, `sel` = 10, with no idle cycle.
  - Then drop `req` to 0000: next edge `grant` = 0000, `busy` = 0, and `sel` stays 10.
- **Wrap-around:** owner 3 with `req` = 1001 and MAX_HOLD = 2.
  - After 2 cycles: `grant` = 0001.
  - After 2 more cycles: `grant` = 1000.
- **Reset mid-operation:** assert `rst` while `grant` = 0100, between clock edges.
  - `grant` = 0000, `sel` = 00 and `busy` = 0 without waiting for an edge.
  - After release with `req` = 1111: first grant = 0001.
- **MAX_HOLD = 1, `req` = 0110:** grant alternates 0010, 0100 every cycle.
